// File: rtl/ysyx_22040895_ifu.sv
// Instruction fetch unit: holds the PC, fetches one instruction per retire, and redirects on EXU commit.
// Optional YSYX_22040895_IFU_MISALIGN_EN traps misaligned jump targets in a sticky FAULT state.
module ysyx_22040895_ifu #(
    parameter int              XLEN     = 64,
    parameter int              ILEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req_valid_o_ifu,
    input  logic            mem_req_ready_i_ifu,
    output logic [XLEN-1:0] mem_req_addr_o_ifu,
    input  logic            mem_rsp_valid_i_ifu,
    input  logic [ILEN-1:0] mem_rsp_data_i_ifu,
    output logic            inst_valid_o_ifu,
    input  logic            inst_ready_i_ifu,
    output logic [ILEN-1:0] inst_o_ifu,
    output logic [XLEN-1:0] pc_o_ifu,
    input  logic            commit_valid_i_ifu,
    input  logic            jump_branch_i_ifu,
    input  logic [XLEN-1:0] dnpc_i_ifu
`ifdef YSYX_22040895_IFU_MISALIGN_EN
    ,
    output logic            misalign_o_ifu
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_EXEC
`ifdef YSYX_22040895_IFU_MISALIGN_EN
        ,
        S_FAULT
`endif
    } state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt, pc_seq;
    logic [ILEN-1:0] inst, inst_nxt;

    assign pc_seq = pc + XLEN'(4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            pc    <= RESET_PC;
            inst  <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            inst  <= inst_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        inst_nxt  = inst;
        case (state)
            S_IDLE: state_nxt = S_REQ;
            S_REQ:  if (mem_req_ready_i_ifu) state_nxt = S_WAIT;
            S_WAIT: begin
                if (mem_rsp_valid_i_ifu) begin
                    inst_nxt  = mem_rsp_data_i_ifu;
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: if (inst_ready_i_ifu) state_nxt = S_EXEC;
            S_EXEC: begin
                if (commit_valid_i_ifu) begin
`ifdef YSYX_22040895_IFU_MISALIGN_EN
                    // A misaligned redirect freezes the PC at the faulting instruction.
                    if (jump_branch_i_ifu && (dnpc_i_ifu[1:0] != 2'b00)) begin
                        state_nxt = S_FAULT;
                    end else begin
                        pc_nxt    = jump_branch_i_ifu ? dnpc_i_ifu : pc_seq;
                        state_nxt = S_REQ;
                    end
`else
                    pc_nxt    = jump_branch_i_ifu ? {dnpc_i_ifu[XLEN-1:2], 2'b00} : pc_seq;
                    state_nxt = S_REQ;
`endif
                end
            end
`ifdef YSYX_22040895_IFU_MISALIGN_EN
            S_FAULT: state_nxt = S_FAULT;
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    assign mem_req_valid_o_ifu = (state == S_REQ);
    assign mem_req_addr_o_ifu  = pc;
    assign inst_valid_o_ifu    = (state == S_HOLD);
    assign inst_o_ifu          = inst;
    assign pc_o_ifu            = pc;
`ifdef YSYX_22040895_IFU_MISALIGN_EN
    assign misalign_o_ifu      = (state == S_FAULT);
`endif

endmodule
